// File: rtl/hv_sync_if.sv
// Sync input pair and recovered timing outputs of the HSYNC/VSYNC decoder.
// master: the video source side (drives syncs, observes recovered timing).
// slave:  the decoder itself.
interface hv_sync_if;
    logic        HSYNC;
    logic        VSYNC;
    logic [10:0] hPos;
    logic [9:0]  vPos;
    logic        videoOn;
    logic        locked;
    logic [11:0] h_period;
    logic [9:0]  v_period;
    logic [7:0]  err_cnt;

    modport master (
        output HSYNC,
        output VSYNC,
        input  hPos,
        input  vPos,
        input  videoOn,
        input  locked,
        input  h_period,
        input  v_period,
        input  err_cnt
    );

    modport slave (
        input  HSYNC,
        input  VSYNC,
        output hPos,
        output vPos,
        output videoOn,
        output locked,
        output h_period,
        output v_period,
        output err_cnt
    );
endinterface

// File: rtl/hv_sync_decoder.sv
// Receive-side HSYNC/VSYNC decoder: detects active-low sync falls, measures line and
// frame periods, runs a lock FSM and regenerates hPos/vPos/videoOn aligned to the source.
module hv_sync_decoder #(
    parameter int unsigned H_ACTIVE   = 800,
    parameter int unsigned H_TOTAL    = 1055,
    parameter int unsigned H_FALL_POS = 842,
    parameter int unsigned V_ACTIVE   = 600,
    parameter int unsigned V_TOTAL    = 627,
    parameter int unsigned V_FALL_POS = 602,
    parameter int unsigned LOCK_LINES = 4
) (
    input  logic        CLK,
    input  logic        rst_n,
    hv_sync_if.slave    bus
);

    localparam logic [10:0] HTotal     = 11'(H_TOTAL);
    localparam logic [10:0] HFallPos   = 11'(H_FALL_POS);
    localparam logic [10:0] HActive    = 11'(H_ACTIVE);
    localparam logic [9:0]  VTotal     = 10'(V_TOTAL);
    localparam logic [9:0]  VFallPos   = 10'(V_FALL_POS);
    localparam logic [9:0]  VActive    = 10'(V_ACTIVE);
    localparam logic [11:0] HPeriod    = 12'(H_TOTAL + 1);
    localparam logic [11:0] TimeoutCyc = 12'(2 * (H_TOTAL + 1));
    localparam logic [9:0]  VPeriod    = 10'(V_TOTAL + 1);
    localparam logic [7:0]  LockLines  = 8'(LOCK_LINES);

    typedef enum logic [2:0] {
        StHunt,
        StMeasure,
        StHLock,
        StVCheck,
        StLocked
    } state_e;

    state_e      state_q, state_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic [11:0] cyc_q, cyc_d;
    logic [9:0]  lcnt_q, lcnt_d;
    logic [10:0] hpos_q, hpos_d;
    logic [9:0]  vpos_q, vpos_d;
    logic [11:0] h_period_q, h_period_d;
    logic [9:0]  v_period_q, v_period_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [7:0]  match_cnt_q, match_cnt_d;

    logic       hfall, vfall, hwrap, timeout, h_bad, v_bad, err_inc;
    logic [7:0] match_inc;

    // Edge detection and period/line-count checks against the expected timing
    always_comb begin
        hfall     = hs_q & ~bus.HSYNC;
        vfall     = vs_q & ~bus.VSYNC;
        hwrap     = ~hfall & (hpos_q == HTotal);
        timeout   = ~hfall & (cyc_q == TimeoutCyc);
        h_bad     = hfall & (cyc_q != HPeriod);
        v_bad     = vfall & (lcnt_q != VPeriod);
        match_inc = match_cnt_q + 8'd1;
    end

    // Measurement counters and recovered position counters
    always_comb begin
        hs_d       = bus.HSYNC;
        vs_d       = bus.VSYNC;
        cyc_d      = cyc_q;
        lcnt_d     = lcnt_q;
        hpos_d     = hpos_q;
        vpos_d     = vpos_q;
        h_period_d = h_period_q;
        v_period_d = v_period_q;

        if (hfall) begin
            h_period_d = cyc_q;
            cyc_d      = 12'd1;
        end else if (cyc_q != 12'hfff) begin
            cyc_d = cyc_q + 12'd1;
        end

        // A coincident hfall belongs to the new frame, hence the reload of 1
        if (vfall) begin
            v_period_d = lcnt_q;
            lcnt_d     = hfall ? 10'd1 : 10'd0;
        end else if (hfall) begin
            lcnt_d = lcnt_q + 10'd1;
        end

        if (hfall) begin
            hpos_d = HFallPos;
        end else if (hwrap) begin
            hpos_d = '0;
        end else begin
            hpos_d = hpos_q + 11'd1;
        end

        if (vfall) begin
            vpos_d = VFallPos;
        end else if (hwrap) begin
            vpos_d = (vpos_q == VTotal) ? 10'd0 : vpos_q + 10'd1;
        end
    end

    // Lock FSM next state; only loss of lock from LOCKED counts as an error
    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        err_inc     = 1'b0;

        if (timeout) begin
            state_d     = StHunt;
            match_cnt_d = '0;
            err_inc     = (state_q == StLocked);
        end else begin
            unique case (state_q)
                StHunt: begin
                    if (hfall) begin
                        state_d     = StMeasure;
                        match_cnt_d = '0;
                    end
                end
                StMeasure: begin
                    if (hfall) begin
                        if (h_bad) begin
                            match_cnt_d = '0;
                        end else begin
                            match_cnt_d = match_inc;
                            if (match_inc == LockLines) begin
                                state_d = StHLock;
                            end
                        end
                    end
                end
                StHLock: begin
                    if (h_bad) begin
                        state_d     = StMeasure;
                        match_cnt_d = '0;
                    end else if (vfall) begin
                        state_d = StVCheck;
                    end
                end
                StVCheck: begin
                    // A mismatching vfall simply becomes the next reference
                    if (h_bad) begin
                        state_d     = StMeasure;
                        match_cnt_d = '0;
                    end else if (vfall && !v_bad) begin
                        state_d = StLocked;
                    end
                end
                StLocked: begin
                    if (h_bad || v_bad) begin
                        state_d     = StHunt;
                        match_cnt_d = '0;
                        err_inc     = 1'b1;
                    end
                end
                default: begin
                    state_d     = StHunt;
                    match_cnt_d = '0;
                end
            endcase
        end

        err_cnt_d = err_cnt_q;
        if (err_inc && (err_cnt_q != 8'hff)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StHunt;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            cyc_q       <= '0;
            lcnt_q      <= '0;
            hpos_q      <= '0;
            vpos_q      <= '0;
            h_period_q  <= '0;
            v_period_q  <= '0;
            err_cnt_q   <= '0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            cyc_q       <= cyc_d;
            lcnt_q      <= lcnt_d;
            hpos_q      <= hpos_d;
            vpos_q      <= vpos_d;
            h_period_q  <= h_period_d;
            v_period_q  <= v_period_d;
            err_cnt_q   <= err_cnt_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign bus.hPos     = hpos_q;
    assign bus.vPos     = vpos_q;
    assign bus.locked   = (state_q == StLocked);
    assign bus.videoOn  = (state_q == StLocked) & (hpos_q < HActive) & (vpos_q < VActive);
    assign bus.h_period = h_period_q;
    assign bus.v_period = v_period_q;
    assign bus.err_cnt  = err_cnt_q;

endmodule
